// File: rtl/dec_step_sequencer.sv
// dec_step_sequencer: run/stop/step/load controller for the
// 4-bit incrementing decoder code, with prescaler and modulo carry.
module dec_step_sequencer #(
  parameter int DIV     = 20000000,
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       single,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] code,
  output logic       tick,
  output logic       carry,
  output logic       sclk,
  output logic       busy,
  output logic       load_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [3:0]    CMAX = 4'(MODULUS - 1);
  localparam logic [4:0]    MODV = 5'(MODULUS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      code_q, code_d;
  logic            tick_q, tick_d;
  logic            carry_q, carry_d;
  logic            sclk_q, sclk_d;
  logic            busy_q, busy_d;
  logic            lerr_q, lerr_d;

  logic            wrap;
  logic [3:0]      code_nxt;
  logic            load_ok;

  assign wrap     = (code_q == CMAX);
  assign code_nxt = wrap ? 4'd0 : code_q + 4'd1;
  assign load_ok  = ({1'b0, load_val} < MODV);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    code_d  = code_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    sclk_d  = sclk_q;
    lerr_d  = lerr_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          code_d = load_ok ? load_val : 4'd0;
          lerr_d = ~load_ok;
        end else if (start) begin
          state_d = RUN;
          presc_d = '0;
        end else if (step) begin
          state_d = STEP;
        end
      end
      STEP: begin
        code_d  = code_nxt;
        carry_d = wrap;
        state_d = IDLE;
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (presc_q == PMAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sclk_d  = ~sclk_q;
          code_d  = code_nxt;
          carry_d = wrap;
          if (single && wrap) begin
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      code_q  <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      lerr_q  <= lerr_d;
    end
  end

  assign code     = code_q;
  assign tick     = tick_q;
  assign carry    = carry_q;
  assign sclk     = sclk_q;
  assign busy     = busy_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_dec_step_sequencer.sv
// tb_dec_step_sequencer: directed plus random checks of two
// sequencer configurations against a cycle-level reference model.
module tb_dec_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       single = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] code0, code1;
  logic       tick0, tick1;
  logic       carry0, carry1;
  logic       sclk0, sclk1;
  logic       busy0, busy1;
  logic       lerr0, lerr1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_step_sequencer #(.DIV(4), .MODULUS(10)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step(step), .single(single), .load(load),
    .load_val(load_val), .code(code0), .tick(tick0),
    .carry(carry0), .sclk(sclk0), .busy(busy0),
    .load_err(lerr0)
  );

  dec_step_sequencer #(.DIV(2), .MODULUS(6)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step(step), .single(single), .load(load),
    .load_val(load_val), .code(code1), .tick(tick1),
    .carry(carry1), .sclk(sclk1), .busy(busy1),
    .load_err(lerr1)
  );

  // reference model: mode 0 idle, 1 run, 2 step
  int mmode[2], mcnt[2], mcode[2], msclk[2], mlerr[2];
  int mtick[2], mcarry[2], mbusy[2];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int mod_of(input int i);
    return (i == 0) ? 10 : 6;
  endfunction

  task automatic advance(input int i);
    mcode[i]  = (mcode[i] + 1) % mod_of(i);
    mcarry[i] = (mcode[i] == 0) ? 1 : 0;
  endtask

  task automatic model(input int i);
    bit was_last;
    mtick[i]  = 0;
    mcarry[i] = 0;
    if (rst) begin
      mmode[i] = 0; mcnt[i] = 0; mcode[i] = 0;
      msclk[i] = 0; mlerr[i] = 0;
    end else if (mmode[i] == 0) begin
      if (load) begin
        if (int'(load_val) < mod_of(i)) begin
          mcode[i] = int'(load_val); mlerr[i] = 0;
        end else begin
          mcode[i] = 0; mlerr[i] = 1;
        end
      end else if (start) begin
        mmode[i] = 1; mcnt[i] = 0;
      end else if (step) begin
        mmode[i] = 2;
      end
    end else if (mmode[i] == 2) begin
      advance(i);
      mmode[i] = 0;
    end else begin
      if (stop) begin
        mmode[i] = 0; mcnt[i] = 0;
      end else begin
        mcnt[i]++;
        if (mcnt[i] == div_of(i)) begin
          mcnt[i] = 0;
          mtick[i] = 1;
          msclk[i] = 1 - msclk[i];
          was_last = (mcode[i] == mod_of(i) - 1);
          advance(i);
          if (single && was_last) mmode[i] = 0;
        end
      end
    end
    mbusy[i] = (mmode[i] != 0) ? 1 : 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("u0.code",  32'(code0),  mcode[0]);
    chk("u0.tick",  32'(tick0),  mtick[0]);
    chk("u0.carry", 32'(carry0), mcarry[0]);
    chk("u0.sclk",  32'(sclk0),  msclk[0]);
    chk("u0.busy",  32'(busy0),  mbusy[0]);
    chk("u0.lerr",  32'(lerr0),  mlerr[0]);
    chk("u1.code",  32'(code1),  mcode[1]);
    chk("u1.tick",  32'(tick1),  mtick[1]);
    chk("u1.carry", 32'(carry1), mcarry[1]);
    chk("u1.sclk",  32'(sclk1),  msclk[1]);
    chk("u1.busy",  32'(busy1),  mbusy[1]);
    chk("u1.lerr",  32'(lerr1),  mlerr[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model(0);
    model(1);
    cmp_all();
  endtask

  int ticks, carries;

  initial begin
    for (int i = 0; i < 2; i++) begin
      mmode[i] = 0; mcnt[i] = 0; mcode[i] = 0; msclk[i] = 0;
      mlerr[i] = 0; mtick[i] = 0; mcarry[i] = 0; mbusy[i] = 0;
    end

    // reset and free run
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst.code", 32'(code0), 0);
    chk("rst.tick", 32'(tick0), 0);
    chk("rst.sclk", 32'(sclk0), 0);
    chk("rst.busy", 32'(busy0), 0);
    rst = 1'b0;
    start = 1'b1;
    cyc();
    ticks = 0;
    carries = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (tick0) ticks++;
      if (carry0) carries++;
      if (k == 4) chk("run.first_tick", 32'(tick0), 1);
      if (k == 3) chk("run.no_early_tick", 32'(tick0), 0);
    end
    chk("run.ticks", ticks, 10);
    chk("run.carries", carries, 1);
    chk("run.wrap_code", 32'(code0), 0);
    chk("run.wrap_carry", 32'(carry0), 1);
    start = 1'b0;
    repeat (4) cyc();
    chk("run.code1", 32'(code0), 1);

    // stop coincident with prescaler expiry
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop.tick", 32'(tick0), 0);
    chk("stop.carry", 32'(carry0), 0);
    chk("stop.busy", 32'(busy0), 0);
    chk("stop.code", 32'(code0), 1);
    cyc();
    chk("stop.hold", 32'(code0), 1);

    // load and step
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    chk("load7.code", 32'(code0), 7);
    chk("load7.err", 32'(lerr0), 0);
    chk("load7.err_u1", 32'(lerr1), 1);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step.busy", 32'(busy0), 1);
      cyc();
      chk("step.code", 32'(code0), (s == 2) ? 0 : 8 + s);
      chk("step.carry", 32'(carry0), (s == 2) ? 1 : 0);
    end
    load = 1'b1; load_val = 4'd12;
    cyc();
    chk("load12.code", 32'(code0), 0);
    chk("load12.err", 32'(lerr0), 1);
    load_val = 4'd3;
    cyc();
    load = 1'b0;
    chk("load3.code", 32'(code0), 3);
    chk("load3.err", 32'(lerr0), 0);

    // single mode
    load = 1'b1; load_val = 4'd4;
    cyc();
    load = 1'b0;
    start = 1'b1; single = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    chk("single.code5", 32'(code1), 5);
    repeat (2) cyc();
    chk("single.code0", 32'(code1), 0);
    chk("single.carry", 32'(carry1), 1);
    chk("single.busy", 32'(busy1), 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("single.hold", 32'(code1), 0);
    end
    chk("single.u0_idle", 32'(busy0), 0);
    single = 1'b0;

    // load beats start beats step
    load = 1'b1; start = 1'b1; step = 1'b1; load_val = 4'd2;
    cyc();
    chk("prio.code0", 32'(code0), 2);
    chk("prio.code1", 32'(code1), 2);
    chk("prio.idle", 32'(busy0), 0);
    load = 1'b0;
    cyc();
    chk("prio.run0", 32'(busy0), 1);
    chk("prio.run1", 32'(busy1), 1);
    start = 1'b0; step = 1'b0;

    // reset in the middle of a run
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    load = 1'b1;
    load_val = (msclk[0] != 0) ? 4'd3 : 4'd4;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 20 && mcode[0] != 5; k++) cyc();
    chk("mid.code5", 32'(code0), 5);
    chk("mid.sclk1", 32'(sclk0), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid.rst_code", 32'(code0), 0);
    chk("mid.rst_sclk", 32'(sclk0), 0);
    chk("mid.rst_tick", 32'(tick0), 0);
    chk("mid.rst_busy", 32'(busy0), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("restart.no_tick", 32'(tick0), 0);
    end
    cyc();
    chk("restart.tick", 32'(tick0), 1);
    chk("restart.code", 32'(code0), 1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(63) == 0);
      load     = ($urandom_range(7) == 0);
      start    = ($urandom_range(7) == 0);
      stop     = ($urandom_range(15) == 0);
      step     = ($urandom_range(3) == 0);
      single   = $urandom_range(1) == 1;
      load_val = 4'($urandom_range(15));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_step_sequencer.md
Name: dec_step_sequencer

Overview:
- Controller that sequences the 4-bit incrementing decoder datapath on the Vaman board.
- Owns the registered 4-bit code presented to the decoder inputs, and the prescaler that turns the system clock into a slow advance tick.
- FSM provides run, stop, single-step and load, plus a modulo wrap with a carry pulse, so several decoder stages can be chained or driven from switches/LEDs.

Parameters:
DIV, 20000000, system-clock cycles per advance tick in RUN (legal 2..2^27-1).
MODULUS, 10, code wraps from MODULUS-1 to 0 (legal 2..16).

Ports:
clk  input  1  system clock (Sys_Clk0 from the qlal4s3b cell macro)
rst  input  1  synchronous, active-high reset
start  input  1  level; request RUN
stop  input  1  level; request IDLE
step  input  1  level; request one advance from IDLE
single  input  1  level; sampled in RUN: 1 = return to IDLE after the wrap
load  input  1  level; load load_val (IDLE only)
load_val  input  4  value to load
code  output  4  current code, drives decoder inputs (bit3 = MSB)
tick  output  1  one-cycle pulse when the prescaler expires in RUN
carry  output  1  one-cycle pulse on the wrap MODULUS-1 -> 0
sclk  output  1  slow square wave, toggles on every tick
busy  output  1  1 while in RUN or STEP
load_err  output  1  sticky; set when load_val >= MODULUS, cleared by rst or a legal load

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high (rst); it overrides all inputs.
- Reset values: state=IDLE, code=0, prescaler=0, tick=0, carry=0, sclk=0, busy=0, load_err=0.
- All outputs are registered. code changes one cycle after the accepting edge.
- Advance operation:
  - If code==MODULUS-1: code<=0 and carry=1 for that cycle.
  - Else: code<=code+1 and carry=0.
  - Arithmetic is 4-bit unsigned. It never produces a value >= MODULUS.
- Prescaler:
  - Width is clog2(DIV). It counts only in RUN and is cleared to 0 on every entry to RUN.
  - When prescaler==DIV-1: prescaler<=0, tick=1 for one cycle, sclk toggles, and one advance occurs on the same edge.
  - First tick comes DIV cycles after the RUN-entry edge.
- FSM states: IDLE, RUN, STEP.
- IDLE: code held, busy=0. Input priority is load > start > step.
  - load:
    - If load_val<MODULUS: code<=load_val, load_err<=0.
    - Else: code<=0, load_err<=1.
    - Stay in IDLE.
  - start (no load): go to RUN, clear prescaler.
  - step (no load, no start): go to STEP.
- STEP: performs exactly one advance (carry if wrapping), busy=1, returns to IDLE next cycle.
  - Inputs are ignored in STEP.
  - step held high produces one advance every 2 cycles (STEP/IDLE alternation). This is intended.
- RUN: busy=1. load and step are ignored.
  - stop: go to IDLE. It has priority over a coincident tick: no advance, no carry, tick still 0 and sclk not toggled that cycle. Prescaler cleared.
  - tick with single=1 and code==MODULUS-1: advance (wrap, carry=1) then go to IDLE.
  - start held in RUN has no effect.
- stop and start both high in IDLE: start accepted; next cycle stop returns to IDLE (one RUN cycle, no tick unless DIV... DIV>=2 guarantees none).
- Reset mid-RUN: immediately IDLE, code=0, sclk=0. Any pending tick is lost.
- sclk holds its level in IDLE. It is not reset by stop.

Test Plan:
1. Reset and run: DIV=4, MODULUS=10, rst 2 cycles, then start held.
   - tick on cycles 4,8,12...
   - code 0,1,...,9,0.
   - carry exactly on the 9->0 edge.
   - sclk toggles each tick.
2. Stop vs tick: DIV=4; assert stop in the same cycle the prescaler reaches 3.
   - No advance, tick=0, carry=0.
   - state IDLE, code unchanged, busy=0 next cycle.
3. Load and step:
   - In IDLE, load load_val=7 -> code=7, load_err=0.
   - Pulse step twice -> code=8, then 9.
   - Step again -> code=0 with carry=1.
   - load load_val=12 -> code=0, load_err=1.
   - load 3 -> load_err=0.
4. Single mode: MODULUS=6, DIV=2, load 4, start with single=1.
   - code 5 then 0 with carry.
   - Then IDLE, busy=0, code stays 0 for 20 cycles.
5. Priority: in IDLE assert load=1, start=1, step=1 with load_val=2.
   - code=2, state stays IDLE.
   - Next cycle with load=0: start wins, RUN.
6. Reset mid-operation: in RUN at code=5, sclk=1, assert rst one cycle.
   - code=0, sclk=0, tick=0, busy=0.
   - Prescaler restarts from 0 on the next start.
